// File: rtl/dram_rw_scheduler_pkg.sv
// Shared types for the DRAM-cache read/write scheduler: FSM states, the command
// slot layout and the cache-index extraction used by the same-set hazard check.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif

package dram_rw_scheduler_pkg;

  typedef enum logic {
    RD_PRIO  = 1'b0,
    WR_DRAIN = 1'b1
  } sched_state_e;

  typedef logic [`INDEX_WIDTH-1:0] index_t;

  typedef struct packed {
    logic [`AXI_ID_WIDTH-1:0]   id;
    logic [`AXI_ADDR_WIDTH-1:0] addr;
    logic [`AXI_DATA_WIDTH-1:0] wdata;
    logic                       write;
  } cmd_t;

  // Set index is the field just above the line offset.
  function automatic index_t cache_index(input logic [`AXI_ADDR_WIDTH-1:0] addr);
    return index_t'(addr >> `OFFSET_WIDTH);
  endfunction

endpackage

// File: rtl/dram_wr_pair_hold.sv
// One-entry AW and W hold registers for fill writes; a write becomes eligible
// once both halves are held. A slot may be refilled in the cycle it is drained.
module dram_wr_pair_hold #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wr_sel,
  output logic                  aw_hold_v,
  output logic [ID_WIDTH-1:0]   aw_hold_id,
  output logic [ADDR_WIDTH-1:0] aw_hold_addr,
  output logic                  w_hold_v,
  output logic [DATA_WIDTH-1:0] w_hold_data,
  output logic                  wr_pair
);

  assign awready = !aw_hold_v | wr_sel;
  assign wready  = !w_hold_v | wr_sel;
  assign wr_pair = aw_hold_v & w_hold_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_hold_v    <= 1'b0;
      aw_hold_id   <= '0;
      aw_hold_addr <= '0;
    end else if (awvalid && awready) begin
      aw_hold_v    <= 1'b1;
      aw_hold_id   <= awid;
      aw_hold_addr <= awaddr;
    end else if (wr_sel) begin
      aw_hold_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_hold_v    <= 1'b0;
      w_hold_data <= '0;
    end else if (wvalid && wready) begin
      w_hold_v    <= 1'b1;
      w_hold_data <= wdata;
    end else if (wr_sel) begin
      w_hold_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_rw_scheduler.sv
// Arbitrates tag-probe reads and fill writes onto one memory-controller command
// slot: read priority, starvation-triggered write drain, same-set hazard ordering.
module dram_rw_scheduler
  import dram_rw_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
  parameter int ID_WIDTH     = `AXI_ID_WIDTH,
  parameter int INDEX_WIDTH  = `INDEX_WIDTH,
  parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
  parameter int STARVE_LIMIT = 8,
  parameter int DRAIN_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ID_WIDTH-1:0]   cmd_id_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_wdata_o,
  output logic                  cmd_write_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  drain_active_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; the command slot holds steady while valid & !ready.

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int DCW = $clog2(DRAIN_BURST + 1);

  sched_state_e          state, state_next;
  logic [SCW-1:0]        starve_cnt;
  logic [DCW-1:0]        drain_cnt, drain_cnt_inc;
  logic                  starve_at_limit;

  logic                  aw_hold_v, w_hold_v, wr_pair;
  logic [ID_WIDTH-1:0]   aw_hold_id;
  logic [ADDR_WIDTH-1:0] aw_hold_addr;
  logic [DATA_WIDTH-1:0] w_hold_data;

  logic                  slot_free, conflict, wr_sel, rd_sel;
  cmd_t                  slot;
  logic                  slot_v;

  dram_wr_pair_hold #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .awid        (awid_i),
    .awaddr      (awaddr_i),
    .awvalid     (awvalid_i),
    .awready     (awready_o),
    .wdata       (wdata_i),
    .wvalid      (wvalid_i),
    .wready      (wready_o),
    .wr_sel      (wr_sel),
    .aw_hold_v   (aw_hold_v),
    .aw_hold_id  (aw_hold_id),
    .aw_hold_addr(aw_hold_addr),
    .w_hold_v    (w_hold_v),
    .w_hold_data (w_hold_data),
    .wr_pair     (wr_pair)
  );

  // A read must not overtake a held fill to the same set, even before its W arrives.
  assign slot_free = !slot_v | cmd_ready_i;
  assign conflict  = arvalid_i & aw_hold_v &
                     (cache_index(araddr_i) == cache_index(aw_hold_addr));
  assign wr_sel    = slot_free & wr_pair &
                     ((state == WR_DRAIN) | conflict | !arvalid_i);
  assign rd_sel    = slot_free & arvalid_i & !conflict & (state == RD_PRIO) & !wr_sel;
  assign arready_o = rd_sel;

  assign starve_at_limit = (starve_cnt == SCW'(STARVE_LIMIT));
  assign drain_cnt_inc   = drain_cnt + DCW'(wr_sel);

  always_comb begin
    state_next = state;
    case (state)
      RD_PRIO: begin
        if (starve_at_limit) state_next = WR_DRAIN;
      end
      WR_DRAIN: begin
        if ((drain_cnt_inc == DCW'(DRAIN_BURST)) || (slot_free && !wr_pair))
          state_next = RD_PRIO;
      end
      default: state_next = RD_PRIO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RD_PRIO;
      starve_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      state <= state_next;
      if (wr_sel)                         starve_cnt <= '0;
      else if (wr_pair && !starve_at_limit) starve_cnt <= starve_cnt + SCW'(1);
      if (state == WR_DRAIN && state_next == WR_DRAIN) drain_cnt <= drain_cnt_inc;
      else                                             drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      slot_v <= 1'b0;
    end else if (wr_sel) begin
      slot   <= '{id: aw_hold_id, addr: aw_hold_addr, wdata: w_hold_data, write: 1'b1};
      slot_v <= 1'b1;
    end else if (rd_sel) begin
      slot   <= '{id: arid_i, addr: araddr_i, wdata: '0, write: 1'b0};
      slot_v <= 1'b1;
    end else if (slot_free) begin
      slot_v <= 1'b0;
    end
  end

  assign cmd_valid_o    = slot_v;
  assign cmd_id_o       = slot.id;
  assign cmd_addr_o     = slot.addr;
  assign cmd_wdata_o    = slot.wdata;
  assign cmd_write_o    = slot.write;
  assign drain_active_o = (state == WR_DRAIN);

endmodule

// File: tb/tb_dram_rw_scheduler.sv
// Bench for dram_rw_scheduler: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based model and by in-order issue scoreboards.
module tb_dram_rw_scheduler;
  localparam int AW = 32, DW = 64, IW = 4, XW = 10, OW = 6, SL = 8, DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] arid_i, awid_i, cmd_id_o;
  logic [AW-1:0] araddr_i, awaddr_i, cmd_addr_o;
  logic [DW-1:0] wdata_i, cmd_wdata_o;
  logic          arvalid_i, arready_o, awvalid_i, awready_o, wvalid_i, wready_o;
  logic          cmd_write_o, cmd_valid_o, cmd_ready_i, drain_active_o;

  always #5 clk = ~clk;

  dram_rw_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .INDEX_WIDTH(XW),
    .OFFSET_WIDTH(OW), .STARVE_LIMIT(SL), .DRAIN_BURST(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .cmd_id_o(cmd_id_o), .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
    .cmd_write_o(cmd_write_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .drain_active_o(drain_active_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending fills as queues, slot as plain variables.
  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; } aw_t;
  aw_t           m_aw_q[$];
  logic [DW-1:0] m_w_q[$];
  bit            m_slot_v, m_slot_write, m_drain;
  logic [IW-1:0] m_slot_id;
  logic [AW-1:0] m_slot_addr;
  logic [DW-1:0] m_slot_wdata;
  int            m_starve, m_burst;
  bit            e_free, e_pair, e_conf, e_take_w, e_take_r;

  // Scoreboards: commands must leave in the order their requests were accepted.
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_wd_q[$];
  int issue_seq = 0, wr_last_at = -1, rd_last_at = -1;
  int reads_accepted = 0, aw_sent = 0, w_sent = 0;

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / (1 << OW)) % (1 << XW));
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int tag, input int idx);
    return AW'(tag) * 32'h1_0000 + AW'(idx) * 32'h40;
  endfunction

  task automatic model_reset();
    m_aw_q.delete(); m_w_q.delete();
    m_slot_v = 0; m_slot_write = 0; m_drain = 0;
    m_slot_id = '0; m_slot_addr = '0; m_slot_wdata = '0;
    m_starve = 0; m_burst = 0;
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
  endtask

  task automatic model_comb();
    e_free   = !m_slot_v || cmd_ready_i;
    e_pair   = (m_aw_q.size() > 0) && (m_w_q.size() > 0);
    e_conf   = arvalid_i && (m_aw_q.size() > 0) && (idx_of(araddr_i) == idx_of(m_aw_q[0].addr));
    e_take_w = e_free && e_pair && (m_drain || e_conf || !arvalid_i);
    e_take_r = e_free && arvalid_i && !e_conf && !m_drain && !e_take_w;
  endtask

  task automatic model_seq();
    bit  was_limit;
    bit  aw_rdy, w_rdy;
    int  nb;
    aw_t a;
    was_limit = (m_starve == SL);
    aw_rdy = (m_aw_q.size() == 0) || e_take_w;
    w_rdy  = (m_w_q.size() == 0) || e_take_w;
    if (e_take_w) begin
      a = m_aw_q.pop_front();
      m_slot_v = 1; m_slot_write = 1; m_slot_id = a.id; m_slot_addr = a.addr;
      m_slot_wdata = m_w_q.pop_front();
    end else if (e_take_r) begin
      m_slot_v = 1; m_slot_write = 0; m_slot_id = arid_i; m_slot_addr = araddr_i;
      m_slot_wdata = '0;
    end else if (e_free) begin
      m_slot_v = 0;
    end
    if (awvalid_i && aw_rdy) m_aw_q.push_back('{awid_i, awaddr_i});
    if (wvalid_i && w_rdy)   m_w_q.push_back(wdata_i);
    if (e_take_w) m_starve = 0;
    else if (e_pair && m_starve < SL) m_starve++;
    if (!m_drain) begin
      if (was_limit) m_drain = 1;
    end else begin
      nb = m_burst + int'(e_take_w);
      if (nb == DB || (e_free && !e_pair)) begin
        m_drain = 0; m_burst = 0;
      end else begin
        m_burst = nb;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit hs_ar, hs_aw, hs_w;
    #1;
    model_comb();
    chk("arready", arready_o, e_take_r);
    chk("awready", awready_o, (m_aw_q.size() == 0) || e_take_w);
    chk("wready", wready_o, (m_w_q.size() == 0) || e_take_w);
    hs_ar = arvalid_i && arready_o;
    hs_aw = awvalid_i && awready_o;
    hs_w  = wvalid_i && wready_o;
    if (hs_ar) begin exp_rd_q.push_back(araddr_i); reads_accepted++; end
    if (hs_aw) exp_wa_q.push_back(awaddr_i);
    if (hs_w)  exp_wd_q.push_back(wdata_i);
    if (cmd_valid_o && cmd_ready_i) begin
      issue_seq++;
      if (cmd_write_o) begin
        wr_last_at = issue_seq;
        if (exp_wa_q.size() == 0 || exp_wd_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_order_addr", cmd_addr_o, exp_wa_q.pop_front());
          chk("wr_order_data", cmd_wdata_o, exp_wd_q.pop_front());
        end
      end else begin
        rd_last_at = issue_seq;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_order_addr", cmd_addr_o, exp_rd_q.pop_front());
      end
    end
    @(posedge clk);
    model_seq();
    @(negedge clk);
    chk("cmd_valid", cmd_valid_o, m_slot_v);
    chk("drain_active", drain_active_o, m_drain);
    if (m_slot_v) begin
      chk("cmd_id", cmd_id_o, m_slot_id);
      chk("cmd_addr", cmd_addr_o, m_slot_addr);
      chk("cmd_write", cmd_write_o, m_slot_write);
      if (m_slot_write) chk("cmd_wdata", cmd_wdata_o, m_slot_wdata);
    end
    if (hs_ar) arvalid_i = 0;
    if (hs_aw) awvalid_i = 0;
    if (hs_w)  wvalid_i = 0;
  endtask

  task automatic drive_idle();
    arvalid_i = 0; awvalid_i = 0; wvalid_i = 0;
    arid_i = '0; araddr_i = '0; awid_i = '0; awaddr_i = '0; wdata_i = '0;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr);
    awvalid_i = 1; awid_i = id; awaddr_i = addr; aw_sent++;
  endtask

  task automatic send_w(input logic [DW-1:0] d);
    wvalid_i = 1; wdata_i = d; w_sent++;
  endtask

  task automatic send_rd_not_idx(input int bad_idx);
    int ix;
    ix = $urandom_range(0, (1 << XW) - 1);
    if (ix == bad_idx) ix = (ix + 1) % (1 << XW);
    arvalid_i = 1; arid_i = IW'($urandom); araddr_i = mk_addr($urandom_range(0, 255), ix);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, cmd_valid_o, 0);
    chk({tag, "_write"}, cmd_write_o, 0);
    chk({tag, "_id"}, cmd_id_o, 0);
    chk({tag, "_addr"}, cmd_addr_o, 0);
    chk({tag, "_wdata"}, cmd_wdata_o, 0);
    chk({tag, "_drain"}, drain_active_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1;
    bit drain_seen, issued;
    rst_n = 0; cmd_ready_i = 1; drive_idle(); model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_arready", arready_o, 0);
    @(negedge clk);
    rst_n = 1;

    // Read only: three back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      arvalid_i = 1; arid_i = IW'(i + 1); araddr_i = AW'(i * 'h40);
      cycle();
    end
    repeat (2) cycle();

    // Write only: AW, then W two cycles later.
    send_aw(4'h5, 32'h1000);
    repeat (2) cycle();
    send_w(64'hDEAD_BEEF_0123_4567);
    repeat (3) cycle();

    // Starvation: a held write against a continuous read stream.
    wr_last_at = -1; drain_seen = 0; issued = 0;
    send_aw(4'h6, mk_addr(12, 3)); send_w({$urandom, $urandom});
    send_rd_not_idx(3);
    cycle();
    r0 = reads_accepted;
    for (int i = 0; i < 40 && !issued; i++) begin
      if (!arvalid_i) send_rd_not_idx(3);
      cycle();
      if (drain_active_o) drain_seen = 1;
      if (wr_last_at >= 0) issued = 1;
    end
    chk("starve_issued", issued, 1);
    chk("starve_wait_le_9", (reads_accepted - r0) <= SL + 1, 1);
    chk("starve_drain_seen", drain_seen, 1);
    r1 = reads_accepted;
    repeat (6) begin
      if (!arvalid_i) send_rd_not_idx(3);
      cycle();
    end
    chk("reads_resume", (reads_accepted - r1) >= 3, 1);
    for (int i = 0; i < 5 && arvalid_i; i++) cycle();
    repeat (2) cycle();

    // Hazard: held AW at index 5, then a read to index 5 with a different tag.
    wr_last_at = -1; rd_last_at = -1;
    send_aw(4'h7, mk_addr(1, 5));
    cycle();
    arvalid_i = 1; arid_i = 4'h8; araddr_i = mk_addr(2, 5);
    repeat (3) cycle();
    send_w(64'h5555_AAAA_0000_0005);
    repeat (5) cycle();
    chk("hazard_both", (wr_last_at > 0) && (rd_last_at > 0), 1);
    chk("hazard_wr_first", wr_last_at < rd_last_at, 1);

    // Same scenario, different index: the read goes first.
    wr_last_at = -1; rd_last_at = -1;
    send_aw(4'h9, mk_addr(3, 5)); send_w(64'h6666);
    cycle();
    arvalid_i = 1; arid_i = 4'hA; araddr_i = mk_addr(4, 6);
    repeat (5) cycle();
    chk("nohazard_both", (wr_last_at > 0) && (rd_last_at > 0), 1);
    chk("nohazard_rd_first", rd_last_at < wr_last_at, 1);

    // Backpressure: controller stalls for five cycles.
    cmd_ready_i = 0;
    arvalid_i = 1; arid_i = 4'h2; araddr_i = 32'h500;
    cycle();
    arvalid_i = 1; arid_i = 4'h3; araddr_i = 32'h540;
    repeat (5) cycle();
    chk("bp_hold_addr", cmd_addr_o, 32'h500);
    chk("bp_hold_valid", cmd_valid_o, 1);
    cmd_ready_i = 1;
    repeat (4) cycle();

    // Random traffic with a small index range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      cmd_ready_i = ($urandom_range(0, 3) != 0);
      if (!arvalid_i && $urandom_range(0, 1) == 1) begin
        arvalid_i = 1; arid_i = IW'($urandom);
        araddr_i = mk_addr($urandom_range(0, 255), $urandom_range(0, 3));
      end
      if (!awvalid_i && aw_sent <= w_sent && $urandom_range(0, 2) == 0)
        send_aw(IW'($urandom), mk_addr($urandom_range(0, 255), $urandom_range(0, 3)));
      if (!wvalid_i && w_sent <= aw_sent && $urandom_range(0, 2) == 0)
        send_w({$urandom, $urandom});
      cycle();
    end
    cmd_ready_i = 1;
    for (int i = 0; i < 100; i++) begin
      if (!awvalid_i && aw_sent < w_sent)
        send_aw(IW'($urandom), mk_addr($urandom_range(0, 255), $urandom_range(0, 3)));
      if (!wvalid_i && w_sent < aw_sent) send_w({$urandom, $urandom});
      cycle();
    end
    chk("rand_rd_drained", exp_rd_q.size(), 0);
    chk("rand_wa_drained", exp_wa_q.size(), 0);
    chk("rand_wd_drained", exp_wd_q.size(), 0);

    // Reset while draining.
    drain_seen = 0;
    send_aw(4'hB, mk_addr(7, 9)); send_w(64'h9999);
    for (int i = 0; i < 30 && !drain_seen; i++) begin
      if (!arvalid_i) send_rd_not_idx(9);
      cycle();
      if (drain_active_o) drain_seen = 1;
    end
    chk("pre_reset_drain", drain_seen, 1);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    drive_idle(); model_reset();
    aw_sent = 0; w_sent = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    cycle();
    chk("post_reset_drain", drain_active_o, 0);
    arvalid_i = 1; arid_i = 4'h1; araddr_i = 32'h2000;
    repeat (3) cycle();
    chk("post_reset_rd_done", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
